// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file geometry defaults, the 6-bit opcode
// map and the writes_reg() predicate. The writeback mux, decode, the
// register file and its scoreboard all import this package.
package cpu_pkg;

    localparam int NREGS  = 32;
    localparam int DWIDTH = 32;
    localparam int AWIDTH = 5;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_NOP   = 6'd0;
    localparam opcode_t OP_ADD   = 6'd1;
    localparam opcode_t OP_SUB   = 6'd2;
    localparam opcode_t OP_STORE = 6'd3;
    localparam opcode_t OP_LOAD  = 6'd4;
    localparam opcode_t OP_MOVE  = 6'd5;
    localparam opcode_t OP_SGE   = 6'd6;
    localparam opcode_t OP_SLE   = 6'd7;
    localparam opcode_t OP_SGT   = 6'd8;
    localparam opcode_t OP_SLT   = 6'd9;
    localparam opcode_t OP_SEQ   = 6'd10;
    localparam opcode_t OP_SNE   = 6'd11;
    localparam opcode_t OP_AND   = 6'd12;
    localparam opcode_t OP_OR    = 6'd13;
    localparam opcode_t OP_XOR   = 6'd14;
    localparam opcode_t OP_NOT   = 6'd15;
    localparam opcode_t OP_MOVEI = 6'd16;
    localparam opcode_t OP_SLI   = 6'd17;
    localparam opcode_t OP_SRI   = 6'd18;
    localparam opcode_t OP_ADDI  = 6'd19;
    localparam opcode_t OP_SUBI  = 6'd20;

    // True for every opcode that produces a register result. NOP, STORE and
    // the undefined range 21..63 write nothing.
    function automatic logic writes_reg(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) ||
               ((op >= OP_LOAD) && (op <= OP_SUBI));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending scoreboard for the register file.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_wb_en, i_wb_rd    architectural write happening this cycle and its target
//   i_issue_valid       decode presents an instruction this cycle
//   i_issue_opcode      opcode of that instruction
//   i_rs1/i_rs2/i_rd    its sources and destination
//   o_stall             combinational hold request back to decode
//
// Issue handshake: an instruction is accepted on a clock edge where
// i_issue_valid is high and o_stall is low; while o_stall is high decode must
// hold every issue input stable. o_stall never depends on anything but the
// current inputs and the pending vector.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS  = cpu_pkg::NREGS,
    parameter int AWIDTH = cpu_pkg::AWIDTH
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wb_en,
    input  logic [AWIDTH-1:0] i_wb_rd,
    input  logic              i_issue_valid,
    input  logic [5:0]        i_issue_opcode,
    input  logic [AWIDTH-1:0] i_rs1,
    input  logic [AWIDTH-1:0] i_rs2,
    input  logic [AWIDTH-1:0] i_rd,
    output logic              o_stall
);

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_clear_mask;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_busy;
    logic             w_issue_writes;
    logic             w_issue_fire;

    always_comb begin
        w_clear_mask = '0;
        if (i_wb_en) begin
            w_clear_mask[i_wb_rd] = 1'b1;
        end

        // A writer completing this very cycle no longer blocks: its data
        // reaches the read ports through the write-through bypass.
        w_busy    = r_pending & ~w_clear_mask;
        w_busy[0] = 1'b0;

        w_issue_writes = writes_reg(i_issue_opcode);
        // Both sources are checked even if the opcode ignores one of them.
        o_stall = i_issue_valid &&
                  (w_busy[i_rs1] || w_busy[i_rs2] ||
                   (w_issue_writes && w_busy[i_rd]));

        w_issue_fire = i_issue_valid && !o_stall && w_issue_writes &&
                       (i_rd != '0);
        w_set_mask = '0;
        if (w_issue_fire) begin
            w_set_mask[i_rd] = 1'b1;
        end
    end

    // Set is OR'ed in after the clear so a new writer to the register being
    // retired this cycle keeps the bit high.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear_mask) | w_set_mask;
        end
    end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Architectural register file at the end of the pipeline, fed by the
// writeback mux. Commits din to rd_d3 for register-writing opcodes, offers two
// registered read ports to decode with write-through bypass, and stalls decode
// on RAW/WAW hazards through the reg_scoreboard sub-module.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   din, rd_d3, opcode_d3           writeback data, target and opcode
//   issue_valid, issue_opcode       decoding instruction presence and opcode
//   rs1_addr, rs2_addr, rd_req      its source and destination registers
//   reg_rs1, reg_rs2                registered read data (1-cycle latency)
//   stall                           combinational hold request to decode
//   wb_commit                       registered, high the cycle after a write
module regfile_wb_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS  = cpu_pkg::NREGS,
    parameter int DWIDTH = cpu_pkg::DWIDTH,
    parameter int AWIDTH = cpu_pkg::AWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] din,
    input  logic [AWIDTH-1:0] rd_d3,
    input  logic [5:0]        opcode_d3,
    input  logic              issue_valid,
    input  logic [5:0]        issue_opcode,
    input  logic [AWIDTH-1:0] rs1_addr,
    input  logic [AWIDTH-1:0] rs2_addr,
    input  logic [AWIDTH-1:0] rd_req,
    output logic [DWIDTH-1:0] reg_rs1,
    output logic [DWIDTH-1:0] reg_rs2,
    output logic              stall,
    output logic              wb_commit
);

    logic [DWIDTH-1:0] r_regs [NREGS];
    logic [DWIDTH-1:0] r_rs1;
    logic [DWIDTH-1:0] r_rs2;
    logic              r_wb_commit;
    logic              w_wb_en;
    logic [DWIDTH-1:0] w_rs1_next;
    logic [DWIDTH-1:0] w_rs2_next;

    // R0 is never written, so reading r_regs[0] always yields the reset zero.
    assign w_wb_en = writes_reg(opcode_d3) && (rd_d3 != '0);

    always_comb begin
        w_rs1_next = r_regs[rs1_addr];
        w_rs2_next = r_regs[rs2_addr];
        if (w_wb_en && (rd_d3 == rs1_addr)) begin
            w_rs1_next = din;
        end
        if (w_wb_en && (rd_d3 == rs2_addr)) begin
            w_rs2_next = din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_wb_commit <= 1'b0;
        end else begin
            if (w_wb_en) begin
                r_regs[rd_d3] <= din;
            end
            r_rs1       <= w_rs1_next;
            r_rs2       <= w_rs2_next;
            r_wb_commit <= w_wb_en;
        end
    end

    assign reg_rs1   = r_rs1;
    assign reg_rs2   = r_rs2;
    assign wb_commit = r_wb_commit;

    reg_scoreboard #(
        .NREGS  (NREGS),
        .AWIDTH (AWIDTH)
    ) u_scoreboard (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_wb_en        (w_wb_en),
        .i_wb_rd        (rd_d3),
        .i_issue_valid  (issue_valid),
        .i_issue_opcode (issue_opcode),
        .i_rs1          (rs1_addr),
        .i_rs2          (rs2_addr),
        .i_rd           (rd_req),
        .o_stall        (stall)
    );

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
module tb_regfile_wb_scoreboard;

    logic        clk;
    logic        reset;
    logic [31:0] din;
    logic [4:0]  rd_d3;
    logic [5:0]  opcode_d3;
    logic        issue_valid;
    logic [5:0]  issue_opcode;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_req;
    logic [31:0] reg_rs1;
    logic [31:0] reg_rs2;
    logic        stall;
    logic        wb_commit;

    int total = 0;
    int bad   = 0;

    // Expected {wb_commit, reg_rs1, reg_rs2} for each clock edge.
    logic [64:0] exp_q[$];

    // Behavioural model state.
    logic [31:0] m_regs [32];
    bit          m_pend [32];

    regfile_wb_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .rd_d3        (rd_d3),
        .opcode_d3    (opcode_d3),
        .issue_valid  (issue_valid),
        .issue_opcode (issue_opcode),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rd_req       (rd_req),
        .reg_rs1      (reg_rs1),
        .reg_rs2      (reg_rs2),
        .stall        (stall),
        .wb_commit    (wb_commit)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    function automatic bit m_writes(input logic [5:0] op);
        return (op == 6'd1) || (op == 6'd2) || (op >= 6'd4 && op <= 6'd20);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic [5:0] op3, input logic [4:0] rd3,
                         input logic [31:0] d, input logic iv, input logic [5:0] iop,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rq);
        @(negedge clk);
        reset        = rst;
        opcode_d3    = op3;
        rd_d3        = rd3;
        din          = d;
        issue_valid  = iv;
        issue_opcode = iop;
        rs1_addr     = a1;
        rs2_addr     = a2;
        rd_req       = rq;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // ---------------- scoreboard / compare process ----------------
    initial begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        forever begin
            bit          wb;
            bit          exp_stall;
            bit          set_fire;
            logic [31:0] e1;
            logic [31:0] e2;
            logic [64:0] exp_v;
            logic [64:0] got;
            @(negedge clk);
            #4;
            wb = m_writes(opcode_d3) && (rd_d3 != 0);
            exp_stall = issue_valid && (
                (m_pend[rs1_addr] && !(wb && rd_d3 == rs1_addr) && rs1_addr != 0) ||
                (m_pend[rs2_addr] && !(wb && rd_d3 == rs2_addr) && rs2_addr != 0) ||
                (m_writes(issue_opcode) && m_pend[rd_req] &&
                 !(wb && rd_d3 == rd_req) && rd_req != 0));
            chk("stall", {63'd0, stall}, {63'd0, exp_stall});
            if (reset) begin
                for (int i = 0; i < 32; i++) begin
                    m_regs[i] = '0;
                    m_pend[i] = 1'b0;
                end
                exp_q.push_back('0);
            end else begin
                e1 = (wb && rd_d3 == rs1_addr) ? din : m_regs[rs1_addr];
                e2 = (wb && rd_d3 == rs2_addr) ? din : m_regs[rs2_addr];
                exp_q.push_back({wb, e1, e2});
                set_fire = issue_valid && !exp_stall && m_writes(issue_opcode) && rd_req != 0;
                if (wb) begin
                    m_regs[rd_d3] = din;
                    m_pend[rd_d3] = 1'b0;
                end
                if (set_fire) m_pend[rd_req] = 1'b1;
            end
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            got   = {wb_commit, reg_rs1, reg_rs2};
            chk("outputs{commit,rs1,rs2}", {31'd0, got[64:32]}, {31'd0, exp_v[64:32]});
            chk("reg_rs2", {32'd0, got[31:0]}, {32'd0, exp_v[31:0]});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; din = '0; rd_d3 = '0; opcode_d3 = '0; issue_valid = 1'b0;
        issue_opcode = '0; rs1_addr = '0; rs2_addr = '0; rd_req = '0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick;
        chk("reset_rs1", {32'd0, reg_rs1}, 64'd0);
        chk("reset_commit", {63'd0, wb_commit}, 64'd0);

        // idle read after reset
        drive(0, 0, 0, 0, 0, 0, 5, 0, 0);
        chk("idle_stall", {63'd0, stall}, 64'd0);
        tick;
        chk("idle_rs1", {32'd0, reg_rs1}, 64'd0);
        chk("idle_rs2", {32'd0, reg_rs2}, 64'd0);
        chk("idle_commit", {63'd0, wb_commit}, 64'd0);

        // write with bypass, then plain read
        drive(0, 6'd1, 5'd7, 32'hDEADBEEF, 0, 0, 7, 0, 0); tick;
        chk("bypass_rs1", {32'd0, reg_rs1}, 64'hDEADBEEF);
        chk("bypass_commit", {63'd0, wb_commit}, 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 7, 0); tick;
        chk("read_r7", {32'd0, reg_rs2}, 64'hDEADBEEF);
        chk("idle_commit2", {63'd0, wb_commit}, 64'd0);

        // non-writing opcodes and R0
        drive(0, 6'd3, 5'd4, 32'h1234, 0, 0, 4, 0, 0); tick;
        chk("store_commit", {63'd0, wb_commit}, 64'd0);
        drive(0, 6'd0, 5'd4, 32'h1234, 0, 0, 4, 0, 0); tick;
        drive(0, 6'd25, 5'd4, 32'h1234, 0, 0, 4, 0, 0); tick;
        chk("undef_commit", {63'd0, wb_commit}, 64'd0);
        drive(0, 6'd19, 5'd0, 32'h55, 0, 0, 4, 0, 0); tick;
        chk("r4_unchanged", {32'd0, reg_rs1}, 64'd0);
        chk("r0_commit", {63'd0, wb_commit}, 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick;
        chk("r0_zero", {32'd0, reg_rs1}, 64'd0);

        // RAW stall on a LOAD
        drive(0, 0, 0, 0, 1, 6'd4, 0, 0, 3);
        chk("load_issue_stall", {63'd0, stall}, 64'd0);
        tick;
        drive(0, 0, 0, 0, 1, 6'd1, 3, 0, 0);
        chk("raw_stall_1", {63'd0, stall}, 64'd1);
        tick;
        drive(0, 0, 0, 0, 1, 6'd1, 3, 0, 0);
        chk("raw_stall_2", {63'd0, stall}, 64'd1);
        tick;
        drive(0, 6'd4, 5'd3, 32'hCAFE0003, 1, 6'd1, 3, 0, 0);
        chk("raw_release", {63'd0, stall}, 64'd0);
        tick;
        chk("raw_bypass", {32'd0, reg_rs1}, 64'hCAFE0003);

        // set wins over clear on the same register
        drive(0, 0, 0, 0, 1, 6'd16, 0, 0, 9); tick;
        drive(0, 6'd16, 5'd9, 32'h99, 1, 6'd16, 0, 0, 9);
        chk("waw_same_cycle", {63'd0, stall}, 64'd0);
        tick;
        drive(0, 0, 0, 0, 1, 6'd1, 9, 0, 0);
        chk("set_wins_stall", {63'd0, stall}, 64'd1);
        tick;
        drive(0, 6'd16, 5'd9, 32'h999, 1, 6'd1, 9, 0, 0);
        chk("second_wb_release", {63'd0, stall}, 64'd0);
        tick;
        chk("second_wb_data", {32'd0, reg_rs1}, 64'h999);

        // reset flushes the scoreboard and drops a same-cycle writeback
        drive(0, 0, 0, 0, 1, 6'd4, 0, 0, 6); tick;
        drive(0, 0, 0, 0, 1, 6'd4, 0, 0, 10); tick;
        drive(0, 0, 0, 0, 1, 6'd1, 6, 10, 0);
        chk("pre_reset_stall", {63'd0, stall}, 64'd1);
        drive(1, 6'd1, 5'd12, 32'h12, 0, 0, 0, 0, 0); tick;
        chk("rst_commit", {63'd0, wb_commit}, 64'd0);
        drive(0, 0, 0, 0, 1, 6'd1, 6, 10, 0);
        chk("post_reset_stall", {63'd0, stall}, 64'd0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 12, 0, 0); tick;
        chk("rst_dropped_wb", {32'd0, reg_rs1}, 64'd0);

        // randomized traffic, register addresses mostly in a small window
        for (int n = 0; n < 600; n++) begin
            logic [4:0] hi;
            hi = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'd7;
            drive($urandom_range(0, 79) == 0,
                  6'($urandom_range(0, 24)),
                  5'($urandom_range(0, hi)),
                  $urandom,
                  1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 24)),
                  5'($urandom_range(0, hi)),
                  5'($urandom_range(0, hi)),
                  5'($urandom_range(0, hi)));
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick;
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
